// File: rtl/ni_output_queue_pkg.sv
// rtl/ni_output_queue_pkg.sv - shared types and width helpers for the NI output queue
//
// Purpose: router info codes carried in the packet info field, plus small
//   constant functions used to size pointers and counters.
// Ports: none (package).
package ni_output_queue_pkg;

  // Packet type codes placed in the info field by the PE controller.
  typedef enum logic [3:0] {
    ROUTER_INFO_ACT      = 4'h0,
    ROUTER_INFO_PSUM     = 4'h1,
    ROUTER_INFO_FIN_COMP = 4'h2,
    ROUTER_INFO_READ     = 4'h3
  } router_info_e;

  // Index width for n items; a single item still needs a 1-bit signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ni_rr_arbiter.sv
// rtl/ni_rr_arbiter.sv - one-hot source arbiter, round-robin or fixed priority
//
// Purpose: picks one requesting source per cycle. In round-robin mode the
//   search starts at an internal pointer that moves just past the winner
//   whenever the grant is accepted; in fixed mode index 0 always wins.
// Ports:
//   clk, rst_n  clock, async active-low reset (pointer -> 0)
//   req         per-source request (already masked by queue-full)
//   accept      the current grant was taken this cycle
//   grant       one-hot grant, zero when nothing requests
module ni_rr_arbiter
  import ni_output_queue_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter bit RR_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               accept,
  output logic [NUM_SRC-1:0] grant
);

  localparam int PW = idx_width(NUM_SRC);

  logic [PW-1:0] ptr;
  logic [PW-1:0] start;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] idx;
  logic          found;
  int            j;

  // Walk the sources starting at `start`, wrapping by subtraction so that
  // non-power-of-two source counts also work.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    j         = 0;
    start     = RR_MODE ? ptr : '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(start) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      idx = PW'(j);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      if (grant_idx == PW'(NUM_SRC - 1)) ptr <= '0;
      else                               ptr <= grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/ni_output_queue.sv
// rtl/ni_output_queue.sv - PE network-interface output queue with credit flow control
//
// Purpose: arbitrates NUM_SRC packet sources, buffers accepted packets in a
//   FIFO_DEPTH queue and drains them to the leaf router, one packet per
//   credit.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   src_valid          per-source packet valid
//   src_info/addr/data per-source packet fields, packed source-major
//   src_ready          one-hot grant; packet taken when valid & ready
//   downstream_credit  one credit returned by the router this cycle
//   router_rdy         at least one credit available
//   out_data_valid     one-cycle strobe per packet sent to the router
//   out_data           {info, addr, data}, zero when not valid
//   fifo_count         queue occupancy
module ni_output_queue
  import ni_output_queue_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int INFO_W      = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int CREDIT_INIT = 8,
  parameter bit RR_MODE     = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*INFO_W-1:0]        src_info,
  input  logic [NUM_SRC*ADDR_W-1:0]        src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]        src_data,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic                             downstream_credit,
  output logic                             router_rdy,
  output logic                             out_data_valid,
  output logic [INFO_W+ADDR_W+DATA_W-1:0]  out_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

  localparam int PKT_W = INFO_W + ADDR_W + DATA_W;
  localparam int AW    = idx_width(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = cnt_width(CREDIT_INIT);

  logic [PKT_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      credit_count;
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [PKT_W-1:0]   in_pkt;

  assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty = (fifo_count == '0);

  // Full blocks every grant, even when the head leaves this same cycle;
  // this keeps the write path free of any dependency on the credit state.
  assign req = full ? '0 : src_valid;
  assign enq = |grant;
  assign deq = !empty && (credit_count != '0);

  assign src_ready  = rst_n ? grant : '0;
  assign router_rdy = (credit_count != '0);

  ni_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (enq),
    .grant  (grant)
  );

  // One-hot grant makes an OR-mux sufficient.
  always_comb begin
    in_pkt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        in_pkt = in_pkt | {src_info[i*INFO_W +: INFO_W],
                           src_addr[i*ADDR_W +: ADDR_W],
                           src_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      credit_count   <= CW'(CREDIT_INIT);
      out_data_valid <= 1'b0;
      out_data       <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);

      case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      out_data_valid <= deq;
      out_data       <= deq ? mem[rd_ptr] : '0;

      // A return and a spend in the same cycle cancel out.
      if (downstream_credit && !deq) begin
        if (credit_count != CW'(CREDIT_INIT)) credit_count <= credit_count + CW'(1);
      end else if (!downstream_credit && deq) begin
        credit_count <= credit_count - CW'(1);
      end
    end
  end

  // A credit returned while all credits are already held is a router bug.
  always_ff @(posedge clk) begin
    if (rst_n && downstream_credit && !deq) begin
      assert (credit_count != CW'(CREDIT_INIT));
    end
  end

endmodule

// File: tb/tb_ni_output_queue.sv
// tb/tb_ni_output_queue.sv - directed self-checking bench for ni_output_queue
module tb_ni_output_queue;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [15:0] src_info;
  logic [63:0] src_addr;
  logic [63:0] src_data;
  logic        downstream_credit;

  logic [3:0]  src_ready;
  logic        router_rdy;
  logic        out_data_valid;
  logic [35:0] out_data;
  logic [2:0]  fifo_count;

  logic [3:0]  src_ready_fp;
  logic        router_rdy_fp;
  logic        out_data_valid_fp;
  logic [35:0] out_data_fp;
  logic [2:0]  fifo_count_fp;

  int checks = 0;
  int errors = 0;

  ni_output_queue #(.RR_MODE(1'b1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .src_valid         (src_valid),
    .src_info          (src_info),
    .src_addr          (src_addr),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .downstream_credit (downstream_credit),
    .router_rdy        (router_rdy),
    .out_data_valid    (out_data_valid),
    .out_data          (out_data),
    .fifo_count        (fifo_count)
  );

  ni_output_queue #(.RR_MODE(1'b0)) dut_fp (
    .clk               (clk),
    .rst_n             (rst_n),
    .src_valid         (src_valid),
    .src_info          (src_info),
    .src_addr          (src_addr),
    .src_data          (src_data),
    .src_ready         (src_ready_fp),
    .downstream_credit (downstream_credit),
    .router_rdy        (router_rdy_fp),
    .out_data_valid    (out_data_valid_fp),
    .out_data          (out_data_fp),
    .fifo_count        (fifo_count_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] rr_pkt(input int i);
    logic [3:0]  inf;
    logic [15:0] adr;
    logic [15:0] dat;
    inf = 4'(i + 1);
    adr = 16'h1000 + 16'(i);
    dat = 16'hA000 + 16'(i);
    return {inf, adr, dat};
  endfunction

  task automatic set_rr_fields();
    for (int i = 0; i < 4; i++) begin
      src_info[i*4 +: 4]   = 4'(i + 1);
      src_addr[i*16 +: 16] = 16'h1000 + 16'(i);
      src_data[i*16 +: 16] = 16'hA000 + 16'(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = '0;
    downstream_credit = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_rr_fields();
    src_valid = 4'hF;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_data_valid); end
    checks++; if (out_data !== 36'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (router_rdy !== 1'b1) begin errors++; $display("FAIL reset_router_rdy got=%b exp=1", router_rdy); end
    checks++; if (dut.credit_count !== 4'd8) begin errors++; $display("FAIL reset_credit got=%0d exp=8", dut.credit_count); end
    checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL reset_src_ready got=%b exp=0000", src_ready); end
    checks++; if ({router_rdy_fp, out_data_valid_fp, fifo_count_fp} !== {1'b1, 1'b0, 3'd0} || out_data_fp !== 36'h0)
      begin errors++; $display("FAIL reset_fp got=%b%b%0d %h exp=1 0 0 0", router_rdy_fp, out_data_valid_fp, fifo_count_fp, out_data_fp); end
    @(negedge clk);
    src_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    logic [3:0] exp_g;
    do_reset();
    set_rr_fields();
    src_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      checks++; if (src_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, src_ready, exp_g); end
      checks++; if (src_ready_fp !== 4'b0001) begin errors++; $display("FAIL fp_grant[%0d] got=%b exp=0001", k, src_ready_fp); end
      if (k >= 2) begin
        checks++; if (out_data_valid !== 1'b1 || out_data !== rr_pkt(k - 2))
          begin errors++; $display("FAIL rr_out[%0d] got=%b/%h exp=1/%h", k, out_data_valid, out_data, rr_pkt(k - 2)); end
      end
      @(negedge clk);
    end
    checks++; if (out_data !== rr_pkt(3)) begin errors++; $display("FAIL rr_out_last got=%h exp=%h", out_data, rr_pkt(3)); end
    // Pointer sits at 1 after the wrap; with only 0 and 3 requesting, 3 wins.
    src_valid = 4'b1001;
    #1;
    checks++; if (src_ready !== 4'b1000) begin errors++; $display("FAIL rr_skip got=%b exp=1000", src_ready); end
    checks++; if (src_ready_fp !== 4'b0001) begin errors++; $display("FAIL fp_skip got=%b exp=0001", src_ready_fp); end
    src_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_credit_stall();
    int  sent;
    int  out_n;
    logic prev;
    do_reset();
    sent = 0; out_n = 0; prev = 1'b0;
    src_info[7:4]  = 4'h2;
    src_addr[31:16] = 16'h0100;
    for (int c = 0; c < 16; c++) begin
      if (prev) sent++;
      if (out_data_valid) begin
        checks++; if (out_data !== {4'h2, 16'h0100, 16'(out_n)})
          begin errors++; $display("FAIL stall_order[%0d] got=%h exp=%h", out_n, out_data, {4'h2, 16'h0100, 16'(out_n)}); end
        out_n++;
      end
      src_valid = (sent < 13) ? 4'b0010 : 4'b0000;
      src_data[31:16] = 16'(sent);
      #1 prev = src_ready[1] & src_valid[1];
      @(negedge clk);
    end
    if (prev) sent++;
    if (out_data_valid) out_n++;
    checks++; if (sent !== 12) begin errors++; $display("FAIL stall_accepted got=%0d exp=12", sent); end
    checks++; if (out_n !== 8) begin errors++; $display("FAIL stall_sent got=%0d exp=8", out_n); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL stall_count got=%0d exp=4", fifo_count); end
    checks++; if (src_ready[1] !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", src_ready[1]); end
    checks++; if (router_rdy !== 1'b0) begin errors++; $display("FAIL stall_router_rdy got=%b exp=0", router_rdy); end
    checks++; if (dut.credit_count !== 4'd0) begin errors++; $display("FAIL stall_credit got=%0d exp=0", dut.credit_count); end
  endtask

  // Continues from the stalled, full queue left by test_credit_stall.
  task automatic test_full_dequeue();
    downstream_credit = 1'b1;
    @(negedge clk);
    downstream_credit = 1'b0;
    #1;
    checks++; if (router_rdy !== 1'b1) begin errors++; $display("FAIL fd_router_rdy got=%b exp=1", router_rdy); end
    checks++; if (src_ready[1] !== 1'b0) begin errors++; $display("FAIL fd_ready_full got=%b exp=0", src_ready[1]); end
    @(negedge clk);
    checks++; if (out_data_valid !== 1'b1 || out_data !== {4'h2, 16'h0100, 16'd8})
      begin errors++; $display("FAIL fd_out got=%b/%h exp=1/%h", out_data_valid, out_data, {4'h2, 16'h0100, 16'd8}); end
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL fd_count got=%0d exp=3", fifo_count); end
    checks++; if (router_rdy !== 1'b0) begin errors++; $display("FAIL fd_router_rdy2 got=%b exp=0", router_rdy); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4 || out_data_valid !== 1'b0)
      begin errors++; $display("FAIL fd_refill got=%0d/%b exp=4/0", fifo_count, out_data_valid); end
    src_valid = '0;
  endtask

  task automatic test_credit_simul();
    do_reset();
    set_rr_fields();
    src_valid = 4'b0001;
    repeat (8) @(posedge clk);
    @(negedge clk);
    src_valid = '0;
    checks++; if (dut.credit_count !== 4'd1) begin errors++; $display("FAIL cs_credit_pre got=%0d exp=1", dut.credit_count); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL cs_count_pre got=%0d exp=1", fifo_count); end
    downstream_credit = 1'b1;
    @(negedge clk);
    downstream_credit = 1'b0;
    checks++; if (out_data_valid !== 1'b1) begin errors++; $display("FAIL cs_out got=%b exp=1", out_data_valid); end
    checks++; if (dut.credit_count !== 4'd1) begin errors++; $display("FAIL cs_credit got=%0d exp=1", dut.credit_count); end
    checks++; if (router_rdy !== 1'b1) begin errors++; $display("FAIL cs_router_rdy got=%b exp=1", router_rdy); end
  endtask

  task automatic test_latency();
    do_reset();
    src_info[11:8]  = 4'h3;
    src_addr[47:32] = 16'h0041;
    src_data[47:32] = 16'hBEEF;
    src_valid = 4'b0100;
    #1;
    checks++; if (src_ready !== 4'b0100) begin errors++; $display("FAIL lat_grant got=%b exp=0100", src_ready); end
    @(negedge clk);
    src_valid = '0;
    checks++; if (out_data_valid !== 1'b0 || fifo_count !== 3'd1)
      begin errors++; $display("FAIL lat_early got=%b/%0d exp=0/1", out_data_valid, fifo_count); end
    @(negedge clk);
    checks++; if (out_data_valid !== 1'b1 || out_data !== 36'h30041BEEF)
      begin errors++; $display("FAIL lat_out got=%b/%h exp=1/30041beef", out_data_valid, out_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL lat_count got=%0d exp=0", fifo_count); end
    @(negedge clk);
    checks++; if (out_data_valid !== 1'b0 || out_data !== 36'h0)
      begin errors++; $display("FAIL lat_pulse got=%b/%h exp=0/0", out_data_valid, out_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    src_valid = '0;
    src_info = '0;
    src_addr = '0;
    src_data = '0;
    downstream_credit = 1'b0;
    test_reset();
    test_rr_fairness();
    test_credit_stall();
    test_full_dequeue();
    test_credit_simul();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
